display_bcd_driver: RTL and testbench

Downstream consumer of the CPU's display output. It captures a binary value and converts it to packed BCD with a sequential double-dabble engine, one bit per cycle. It then drives DIGITS active-low seven-segment displays (HEX0 is the least significant digit). Replaces software-side decimal conversion and gives the board a glitch-free, registered display.

---
 rtl/display_bcd_if.sv | 23 ++
 rtl/display_bcd_driver.sv | 184 ++++++++++++++++++
 tb/tb_display_bcd_driver.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/display_bcd_if.sv
// Capture/result bundle between a display source and the BCD display driver.
// master drives load/value; slave returns status, packed BCD and segments.
interface display_bcd_if #(
    parameter int IN_W   = 26,
    parameter int DIGITS = 8
);
    logic                  load;
    logic [IN_W-1:0]       value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   hex;

    modport master (
        output load, value,
        input  busy, done, bcd, hex
    );

    modport slave (
        input  load, value,
        output busy, done, bcd, hex
    );
endinterface

// File: rtl/display_bcd_driver.sv
// Binary-to-BCD (sequential double dabble) with registered active-low 7-segment outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks displays above the most significant non-zero digit.
//
// state  | meaning
// IDLE   | waiting for load
// SHIFT  | double-dabble: add-3 adjust then shift, one input bit per cycle
// UPDATE | publish bcd/hex, pulse done, restart if a value is pending
module display_bcd_driver #(
    parameter int IN_W   = 26,
    parameter int DIGITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    display_bcd_if.slave  bus
);

    localparam int BW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    function automatic int dec_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    generate
        if (IN_W < 1 || IN_W > 63 || dec_digits(IN_W) > DIGITS) begin : g_range_check
            $error("display_bcd_driver: 2^IN_W-1 does not fit in DIGITS decimal digits");
        end
    endgenerate

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [BW-1:0]     acc, acc_n, acc_adj;
    logic [IN_W-1:0]   sr, sr_n;
    logic [CW-1:0]     count, count_n;
    logic              pend, pend_n;
    logic [IN_W-1:0]   pend_val, pend_val_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [BW-1:0]     bcd_q, bcd_n;
    logic [HW-1:0]     hex_q, hex_n, hex_enc;

    // Add-3 on every nibble >= 5, applied before the shift.
    always_comb begin
        acc_adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        hex_enc = '1;
`ifdef LEADING_ZERO_BLANK_EN
        begin : blk_lzb
            logic lead;
            lead = 1'b1;
            for (int k = DIGITS - 1; k >= 0; k--) begin
                if (acc[4*k +: 4] != 4'd0)
                    lead = 1'b0;
                hex_enc[7*k +: 7] = (lead && k != 0) ? 7'h7F : seg7(acc[4*k +: 4]);
            end
        end
`else
        for (int k = 0; k < DIGITS; k++)
            hex_enc[7*k +: 7] = seg7(acc[4*k +: 4]);
`endif
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        sr_n       = sr;
        count_n    = count;
        pend_n     = pend;
        pend_val_n = pend_val;
        busy_n     = busy_q;
        done_n     = 1'b0;
        bcd_n      = bcd_q;
        hex_n      = hex_q;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    sr_n    = bus.value;
                    acc_n   = '0;
                    count_n = CW'(IN_W);
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                {acc_n, sr_n} = {acc_adj[BW-2:0], sr, 1'b0};
                count_n       = count - CW'(1);
                if (count == CW'(1))
                    state_n = UPDATE;
                if (bus.load) begin
                    pend_n     = 1'b1;
                    pend_val_n = bus.value;
                end
            end
            UPDATE: begin
                bcd_n  = acc;
                hex_n  = hex_enc;
                done_n = 1'b1;
                // A load arriving in this very cycle is newer than any pending value.
                if (bus.load || pend) begin
                    sr_n    = bus.load ? bus.value : pend_val;
                    acc_n   = '0;
                    count_n = CW'(IN_W);
                    pend_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            sr       <= '0;
            count    <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            hex_q    <= '1;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            sr       <= sr_n;
            count    <= count_n;
            pend     <= pend_n;
            pend_val <= pend_val_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            bcd_q    <= bcd_n;
            hex_q    <= hex_n;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.hex  = hex_q;

endmodule

// File: tb/tb_display_bcd_driver.sv
// Directed bench for display_bcd_driver: latency, conversion values, pending restart and reset abort.
module tb_display_bcd_driver;

    localparam int IN_W   = 26;
    localparam int DIGITS = 8;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    display_bcd_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

    display_bcd_driver #(.IN_W(IN_W), .DIGITS(DIGITS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [IN_W-1:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        n_cmp += 4;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.bcd !== 32'h0) begin n_bad++; $display("FAIL reset_bcd got %h want 0", bus.bcd); end
        if (bus.hex !== {56{1'b1}}) begin n_bad++; $display("FAIL reset_hex got %h want all ones", bus.hex); end
    endtask

    task automatic test_zero();
        int n;
        logic [55:0] exp_hex;
        exp_hex = LZB ? {{7{7'h7F}}, 7'h40} : {8{7'h40}};
        do_load(26'd0);
        wait_done(n);
        n_cmp += 3;
        if (n !== 27) begin n_bad++; $display("FAIL zero_latency got %0d want 27", n); end
        if (bus.bcd !== 32'h00000000) begin n_bad++; $display("FAIL zero_bcd got %h want 00000000", bus.bcd); end
        if (bus.hex !== exp_hex) begin n_bad++; $display("FAIL zero_hex got %h want %h", bus.hex, exp_hex); end
        tick();
    endtask

    task automatic test_12345();
        int bad;
        logic [55:0] exp_hex;
        exp_hex = LZB ? {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}
                      : {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
        bad = 0;
        do_load(26'd12345);
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL busy_window bad cycles %0d want 0", bad); end
        tick();
        n_cmp += 6;
        if (bus.done !== 1'b1) begin n_bad++; $display("FAIL done_at_27 got %b want 1", bus.done); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_drop got %b want 0", bus.busy); end
        if (bus.bcd !== 32'h00012345) begin n_bad++; $display("FAIL bcd_12345 got %h want 00012345", bus.bcd); end
        if (bus.hex !== exp_hex) begin n_bad++; $display("FAIL hex_12345 got %h want %h", bus.hex, exp_hex); end
        tick();
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
        if (bus.bcd !== 32'h00012345) begin n_bad++; $display("FAIL bcd_hold got %h want 00012345", bus.bcd); end
    endtask

    task automatic test_max();
        int n;
        logic [55:0] exp_hex;
        exp_hex = {7'h02, 7'h78, 7'h79, 7'h40, 7'h00, 7'h00, 7'h02, 7'h30};
        do_load(26'd67108863);
        wait_done(n);
        n_cmp += 3;
        if (n !== 27) begin n_bad++; $display("FAIL max_latency got %0d want 27", n); end
        if (bus.bcd !== 32'h67108863) begin n_bad++; $display("FAIL max_bcd got %h want 67108863", bus.bcd); end
        if (bus.hex !== exp_hex) begin n_bad++; $display("FAIL max_hex got %h want %h", bus.hex, exp_hex); end
        tick();
    endtask

    task automatic test_back_to_back();
        int ndone, d1, d2, busy_bad;
        logic [31:0] b1, b2;
        logic [55:0] h1, h2, e1, e2;
        e1 = LZB ? {{7{7'h7F}}, 7'h12} : {{7{7'h40}}, 7'h12};
        e2 = LZB ? {{7{7'h7F}}, 7'h78} : {{7{7'h40}}, 7'h78};
        ndone = 0; d1 = 0; d2 = 0; busy_bad = 0;
        b1 = '0; b2 = '0; h1 = '0; h2 = '0;
        do_load(26'd5);
        for (int e = 1; e <= 60; e++) begin
            bus.load  = (e == 3 || e == 10);
            bus.value = (e == 3) ? 26'd9 : 26'd7;
            tick();
            bus.load = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin d1 = e; b1 = bus.bcd; h1 = bus.hex; end
                if (ndone == 2) begin d2 = e; b2 = bus.bcd; h2 = bus.hex; end
            end
            if (e < 54 && bus.busy !== 1'b1) busy_bad++;
        end
        n_cmp += 9;
        if (ndone !== 2) begin n_bad++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        if (d1 !== 27) begin n_bad++; $display("FAIL b2b_first_done got %0d want 27", d1); end
        if (d2 !== 54) begin n_bad++; $display("FAIL b2b_second_done got %0d want 54", d2); end
        if (b1 !== 32'h5) begin n_bad++; $display("FAIL b2b_first_bcd got %h want 5", b1); end
        if (b2 !== 32'h7) begin n_bad++; $display("FAIL b2b_second_bcd got %h want 7", b2); end
        if (h1 !== e1) begin n_bad++; $display("FAIL b2b_first_hex got %h want %h", h1, e1); end
        if (h2 !== e2) begin n_bad++; $display("FAIL b2b_second_hex got %h want %h", h2, e2); end
        if (busy_bad !== 0) begin n_bad++; $display("FAIL b2b_busy_gap got %0d want 0", busy_bad); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_final_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        int n, ndone, nbusy;
        logic [55:0] exp_hex;
        exp_hex = LZB ? {{5{7'h7F}}, 7'h10, 7'h10, 7'h10} : {{5{7'h40}}, 7'h10, 7'h10, 7'h10};
        ndone = 0; nbusy = 0;
        do_load(26'd999);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        n_cmp += 4;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", bus.done); end
        if (bus.bcd !== 32'h0) begin n_bad++; $display("FAIL abort_bcd got %h want 0", bus.bcd); end
        if (bus.hex !== {56{1'b1}}) begin n_bad++; $display("FAIL abort_hex got %h want all ones", bus.hex); end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
            if (bus.busy === 1'b1) nbusy++;
        end
        n_cmp += 2;
        if (ndone !== 0) begin n_bad++; $display("FAIL abort_late_done got %0d want 0", ndone); end
        if (nbusy !== 0) begin n_bad++; $display("FAIL abort_late_busy got %0d want 0", nbusy); end
        do_load(26'd999);
        wait_done(n);
        n_cmp += 3;
        if (n !== 27) begin n_bad++; $display("FAIL after_reset_latency got %0d want 27", n); end
        if (bus.bcd !== 32'h00000999) begin n_bad++; $display("FAIL after_reset_bcd got %h want 00000999", bus.bcd); end
        if (bus.hex !== exp_hex) begin n_bad++; $display("FAIL after_reset_hex got %h want %h", bus.hex, exp_hex); end
        tick();
    endtask

    task automatic test_leading_zero();
        int n;
        logic [55:0] e42, e0;
        e42 = LZB ? {{6{7'h7F}}, 7'h19, 7'h24} : {{6{7'h40}}, 7'h19, 7'h24};
        e0  = LZB ? {{7{7'h7F}}, 7'h40} : {8{7'h40}};
        do_load(26'd42);
        wait_done(n);
        n_cmp += 3;
        if (n !== 27) begin n_bad++; $display("FAIL lz42_latency got %0d want 27", n); end
        if (bus.bcd !== 32'h00000042) begin n_bad++; $display("FAIL lz42_bcd got %h want 00000042", bus.bcd); end
        if (bus.hex !== e42) begin n_bad++; $display("FAIL lz42_hex got %h want %h", bus.hex, e42); end
        do_load(26'd0);
        wait_done(n);
        n_cmp += 2;
        if (bus.bcd !== 32'h0) begin n_bad++; $display("FAIL lz0_bcd got %h want 0", bus.bcd); end
        if (bus.hex !== e0) begin n_bad++; $display("FAIL lz0_hex got %h want %h", bus.hex, e0); end
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_zero();
        test_12345();
        test_max();
        test_back_to_back();
        test_reset_abort();
        test_leading_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
